// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key matrix scanner
// Purpose: FSM state encoding, event code width and a counter-width helper.
// Ports: none (package).
package key_pkg;

  localparam int KEY_CODE_W = 8;
  localparam int KEY_MAX    = 256;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    COMPARE,
    EMIT
  } key_state_t;

  // Width of a counter/index that must hold 0..n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_col_sync.sv
// rtl/key_col_sync.sv - two-flop synchronizer for the raw matrix columns
// Purpose: bring the asynchronous, pulled-high column pins into the clk domain.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset; output resets to all 1 (no key)
//   d    - raw asynchronous column inputs
//   q    - synchronized column inputs
module key_col_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// rtl/key_matrix_scan.sv - row-sequenced key matrix scanner with frame debounce
// Purpose: drives one active-low row at a time, samples the active-low columns
//   into a frame, debounces whole frames and emits press/release events.
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   scan_en         - enables scanning (acted on at frame boundaries)
//   col_n           - raw active-low column inputs
//   row_n           - active-low row drives, at most one bit low
//   evt_valid/ready - event handshake
//   evt_code        - key index row*COLS+col
//   evt_press       - 1 press, 0 release
//   busy            - FSM not idle
module key_matrix_scan
  import key_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYC     = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_en,
  input  logic [COLS-1:0]       col_n,
  output logic [ROWS-1:0]       row_n,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [KEY_CODE_W-1:0] evt_code,
  output logic                  evt_press,
  output logic                  busy
);

  localparam int NKEYS = ROWS * COLS;
  localparam int ROW_W = cnt_w(ROWS);
  localparam int IDX_W = cnt_w(NKEYS);
  localparam int SET_W = cnt_w(SETTLE_CYC);
  localparam int STB_W = cnt_w(DEBOUNCE_SCANS + 1);

  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NKEYS - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [STB_W-1:0] STB_MAX     = STB_W'(DEBOUNCE_SCANS);

  key_state_t       state, state_nxt;
  logic [ROW_W-1:0] row;
  logic [SET_W-1:0] settle_cnt;
  logic [STB_W-1:0] stable_cnt;
  logic [IDX_W-1:0] idx;
  logic [NKEYS-1:0] frame, prev_frame, deb_state;
  logic [COLS-1:0]  col_sync;

  logic             frame_same;
  logic [STB_W-1:0] stable_upd;
  logic             cmp_emit;
  logic             key_diff;
  logic             emit_last;
  logic             emit_step;
  logic             emit_done;

  key_col_sync #(.WIDTH(COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_sync)
  );

  // Debounce and emit decisions shared by the next-state and datapath logic.
  always_comb begin
    frame_same = (frame == prev_frame);
    if (!frame_same)
      stable_upd = '0;
    else if (stable_cnt == STB_MAX)
      stable_upd = stable_cnt;
    else
      stable_upd = stable_cnt + STB_W'(1);
    // frame == prev_frame whenever stable_upd reaches the max, so comparing
    // frame against deb_state is the same as comparing the new prev_frame.
    cmp_emit  = (stable_upd == STB_MAX) && (frame != deb_state);
    key_diff  = (deb_state[idx] != prev_frame[idx]);
    emit_last = (idx == IDX_LAST);
    // An unchanged key is skipped in one cycle; a changed one waits for ready.
    emit_step = !key_diff || evt_ready;
    emit_done = emit_step && emit_last;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scan_en) state_nxt = DRIVE;
      DRIVE:   if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (row == ROW_LAST) ? COMPARE : DRIVE;
      COMPARE: begin
        if (cmp_emit)     state_nxt = EMIT;
        else if (scan_en) state_nxt = DRIVE;
        else              state_nxt = IDLE;
      end
      EMIT:    if (emit_done) state_nxt = scan_en ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters and frame registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row        <= '0;
      settle_cnt <= '0;
      stable_cnt <= '0;
      idx        <= '0;
      frame      <= '0;
      prev_frame <= '0;
      deb_state  <= '0;
    end else begin
      case (state)
        IDLE: begin
          row        <= '0;
          settle_cnt <= '0;
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) settle_cnt <= '0;
          else                           settle_cnt <= settle_cnt + SET_W'(1);
        end
        SAMPLE: begin
          frame[int'(row)*COLS +: COLS] <= ~col_sync;
          settle_cnt <= '0;
          if (row != ROW_LAST) row <= row + ROW_W'(1);
        end
        COMPARE: begin
          row <= '0;
          idx <= '0;
          if (!frame_same) prev_frame <= frame;
          // Leaving for IDLE restarts debounce so a resumed scan starts fresh.
          if (!cmp_emit && !scan_en) stable_cnt <= '0;
          else                       stable_cnt <= stable_upd;
        end
        EMIT: begin
          if (key_diff && evt_ready) deb_state[idx] <= ~deb_state[idx];
          if (emit_step && !emit_last) idx <= idx + IDX_W'(1);
          if (emit_done && !scan_en) stable_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    row_n = '1;
    if (state == DRIVE || state == SAMPLE) row_n[row] = 1'b0;
    evt_valid = (state == EMIT) && key_diff;
    evt_code  = evt_valid ? KEY_CODE_W'(idx) : '0;
    evt_press = evt_valid & prev_frame[idx];
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb/tb_key_matrix_scan.sv - self-checking bench for key_matrix_scan
module tb_key_matrix_scan;

  typedef struct packed {
    logic [7:0] code;
    logic       press;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_press;
  logic       busy;

  logic [15:0] keys;
  evt_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          valid_seen = 0;

  key_matrix_scan #(
    .ROWS(4), .COLS(4), .SETTLE_CYC(16), .DEBOUNCE_SCANS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .col_n     (col_n),
    .row_n     (row_n),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) if (evt_valid === 1'b1) valid_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  // Waits for the first cycle with row 0 driven after all rows were high.
  task automatic align();
    logic [3:0] prev;
    bit ok;
    ok = 0;
    prev = row_n;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (prev == 4'hF && row_n == 4'hE) ok = 1;
      prev = row_n;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL align: frame start not seen in 200 cycles, row_n=%h", row_n);
    end
  endtask

  // Waits up to max_cyc negedges for evt_valid; completes the handshake if ready.
  task automatic wait_evt(input int max_cyc, output bit ok, output evt_t got, output int cyc);
    ok = 0;
    cyc = 0;
    got = '0;
    while (cyc < max_cyc && !ok) begin
      @(negedge clk);
      cyc++;
      if (evt_valid) begin
        ok = 1;
        got.code = evt_code;
        got.press = evt_press;
      end
    end
    if (ok && evt_ready) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_en = 1'b0; evt_ready = 1'b1; keys = '0;
    repeat (3) @(negedge clk);
    checks++; if (row_n !== 4'hF) begin failures++; $display("FAIL reset_row_n: got %h want f", row_n); end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
    checks++; if (evt_code !== 8'd0) begin failures++; $display("FAIL reset_evt_code: got %0d want 0", evt_code); end
    checks++; if (evt_press !== 1'b0) begin failures++; $display("FAIL reset_evt_press: got %b want 0", evt_press); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_row_walk();
    int v0, bad, bad_busy, pos;
    logic [3:0] exp_row;
    v0 = valid_seen;
    scan_en = 1'b1;
    @(posedge clk);
    for (int f = 0; f < 2; f++) begin
      bad = 0; bad_busy = 0;
      for (int t = 0; t < 69; t++) begin
        @(negedge clk);
        pos = t;
        if (pos == 68) exp_row = 4'hF;
        else exp_row = 4'hF ^ (4'd1 << (pos / 17));
        if (row_n !== exp_row) bad++;
        if (busy !== 1'b1) bad_busy++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL row_walk_frame%0d: %0d cycles off pattern, want 0", f, bad); end
      checks++; if (bad_busy != 0) begin failures++; $display("FAIL row_walk_busy%0d: busy low %0d cycles, want 0", f, bad_busy); end
    end
    checks++; if (valid_seen != v0) begin failures++; $display("FAIL row_walk_no_event: %0d valid cycles, want 0", valid_seen - v0); end
  endtask

  task automatic test_key_hold();
    bit ok; evt_t got, e; int cyc, v0;
    align();
    keys[6] = 1'b1; exp_q.push_back('{code: 8'd6, press: 1'b1});
    wait_evt(400, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (!ok) begin failures++; $display("FAIL hold_press_seen: no event in 400 cycles"); end
    checks++; if (got !== e) begin failures++; $display("FAIL hold_press_evt: got code %0d press %b want code %0d press %b", got.code, got.press, e.code, e.press); end
    checks++; if (cyc != 351) begin failures++; $display("FAIL hold_press_latency: got %0d want 351", cyc); end
    v0 = valid_seen;
    repeat (150) @(negedge clk);
    checks++; if (valid_seen != v0) begin failures++; $display("FAIL hold_single_event: %0d extra valid cycles, want 0", valid_seen - v0); end
    align();
    keys[6] = 1'b0; exp_q.push_back('{code: 8'd6, press: 1'b0});
    wait_evt(400, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (got !== e || !ok) begin failures++; $display("FAIL hold_release_evt: got code %0d press %b want code %0d press %b", got.code, got.press, e.code, e.press); end
    checks++; if (cyc != 351) begin failures++; $display("FAIL hold_release_latency: got %0d want 351", cyc); end
  endtask

  task automatic test_chatter();
    bit ok; evt_t got, e; int cyc, v0;
    align();
    v0 = valid_seen;
    for (int i = 0; i < 300; i++) begin
      keys[0] = ((i / 50) % 2 == 0);
      @(negedge clk);
    end
    checks++; if (valid_seen != v0) begin failures++; $display("FAIL chatter_quiet: %0d valid cycles during chatter, want 0", valid_seen - v0); end
    keys[0] = 1'b1; exp_q.push_back('{code: 8'd0, press: 1'b1});
    wait_evt(600, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (got !== e || !ok) begin failures++; $display("FAIL chatter_press_evt: got code %0d press %b want code %0d press %b", got.code, got.press, e.code, e.press); end
    checks++; if (cyc + 300 != 690) begin failures++; $display("FAIL chatter_latency: got %0d want 690", cyc + 300); end
    align();
    keys[0] = 1'b0; exp_q.push_back('{code: 8'd0, press: 1'b0});
    wait_evt(400, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (got !== e || !ok) begin failures++; $display("FAIL chatter_release_evt: got code %0d press %b want code %0d press %b", got.code, got.press, e.code, e.press); end
    checks++; if (cyc != 345) begin failures++; $display("FAIL chatter_release_latency: got %0d want 345", cyc); end
  endtask

  task automatic test_back_to_back_stall();
    bit ok; evt_t got, e; int cyc, bad;
    align();
    keys[1] = 1'b1; keys[15] = 1'b1; evt_ready = 1'b0;
    exp_q.push_back('{code: 8'd1, press: 1'b1});
    exp_q.push_back('{code: 8'd15, press: 1'b1});
    wait_evt(400, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (got !== e || !ok) begin failures++; $display("FAIL stall_first_evt: got code %0d press %b want code %0d press %b", got.code, got.press, e.code, e.press); end
    checks++; if (cyc != 346) begin failures++; $display("FAIL stall_first_latency: got %0d want 346", cyc); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (evt_valid !== 1'b1 || evt_code !== 8'd1 || evt_press !== 1'b1 || row_n !== 4'hF) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold: %0d unstable cycles, want 0", bad); end
    evt_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_evt(40, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (got !== e || !ok) begin failures++; $display("FAIL stall_second_evt: got code %0d press %b want code %0d press %b", got.code, got.press, e.code, e.press); end
    checks++; if (cyc != 13) begin failures++; $display("FAIL stall_second_gap: got %0d want 13", cyc); end
    align();
    keys[1] = 1'b0; keys[15] = 1'b0;
    exp_q.push_back('{code: 8'd1, press: 1'b0});
    exp_q.push_back('{code: 8'd15, press: 1'b0});
    for (int k = 0; k < 2; k++) begin
      wait_evt(400, ok, got, cyc);
      e = exp_q.pop_front();
      checks++; if (got !== e || !ok) begin failures++; $display("FAIL stall_release%0d: got code %0d press %b want code %0d press %b", k, got.code, got.press, e.code, e.press); end
    end
  endtask

  task automatic test_scan_disable();
    int n, bad, v0;
    align();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) bad++;
    end
    scan_en = 1'b0;
    n = 30;
    while (busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != 69) begin failures++; $display("FAIL disable_frame_end: idle at cycle %0d want 69", n); end
    checks++; if (row_n !== 4'hF || busy !== 1'b0) begin failures++; $display("FAIL disable_idle: row_n %h busy %b want f 0", row_n, busy); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (row_n !== 4'hF || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL disable_steady: %0d bad cycles want 0", bad); end
    v0 = valid_seen;
    scan_en = 1'b1;
    repeat (6 * 69) @(negedge clk);
    checks++; if (valid_seen != v0) begin failures++; $display("FAIL reenable_no_event: %0d valid cycles want 0", valid_seen - v0); end
  endtask

  task automatic test_reset_mid_emit();
    bit ok; evt_t got, e; int cyc;
    align();
    keys[2] = 1'b1; keys[9] = 1'b1; evt_ready = 1'b1;
    exp_q.push_back('{code: 8'd2, press: 1'b1});
    exp_q.push_back('{code: 8'd9, press: 1'b1});
    wait_evt(400, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (got !== e || !ok || cyc != 347) begin failures++; $display("FAIL rstemit_first: got code %0d press %b at %0d want code %0d press %b at 347", got.code, got.press, cyc, e.code, e.press); end
    evt_ready = 1'b0;
    wait_evt(20, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (got !== e || !ok || cyc != 6) begin failures++; $display("FAIL rstemit_stalled: got code %0d press %b at %0d want code %0d press %b at 6", got.code, got.press, cyc, e.code, e.press); end
    rst = 1'b1;
    #1;
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rstemit_valid_drop: got %b want 0", evt_valid); end
    checks++; if (busy !== 1'b0 || row_n !== 4'hF) begin failures++; $display("FAIL rstemit_idle: busy %b row_n %h want 0 f", busy, row_n); end
    @(negedge clk);
    rst = 1'b0; evt_ready = 1'b1;
    exp_q.push_back('{code: 8'd2, press: 1'b1});
    exp_q.push_back('{code: 8'd9, press: 1'b1});
    wait_evt(400, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (got !== e || !ok) begin failures++; $display("FAIL rstemit_reemit2: got code %0d press %b want code %0d press %b", got.code, got.press, e.code, e.press); end
    checks++; if (cyc != 348) begin failures++; $display("FAIL rstemit_reemit_latency: got %0d want 348", cyc); end
    wait_evt(20, ok, got, cyc);
    e = exp_q.pop_front();
    checks++; if (got !== e || !ok || cyc != 6) begin failures++; $display("FAIL rstemit_reemit9: got code %0d press %b at %0d want code %0d press %b at 6", got.code, got.press, cyc, e.code, e.press); end
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0; evt_ready = 1'b1; keys = '0;
    test_reset();
    test_row_walk();
    test_key_hold();
    test_chatter();
    test_back_to_back_stall();
    test_scan_disable();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
